// File: rtl/ntt_bfu_pkg.sv
// Shared definitions for the NTT butterfly unit: opcodes, side-band stage record, latency helper.
package ntt_bfu_pkg;

  typedef enum logic [1:0] {
    OP_CT  = 2'b00,
    OP_GS  = 2'b01,
    OP_MUL = 2'b10,
    OP_BYP = 2'b11
  } op_e;

  // Control side-band carried next to each stage; the tag travels in a parallel TAGW-wide line.
  typedef struct packed {
    logic valid;
    op_e  op;
    logic half;
  } bfu_sb_t;

  function automatic int unsigned bfu_lat(input int unsigned mul_lat);
    return mul_lat + 2;
  endfunction

endpackage

// File: rtl/bfu_v1_if.sv
// Operand/result bundle of the butterfly unit; master drives operations, slave is the datapath.
interface bfu_v1_if #(
  parameter int unsigned DATAW = 14,
  parameter int unsigned TAGW  = 8
);
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [1:0]       op;
  logic             half;
  logic [TAGW-1:0]  in_tag;
  logic [DATAW-1:0] a;
  logic [DATAW-1:0] b;
  logic [DATAW-1:0] w;
  logic [DATAW-1:0] p;
  logic [DATAW:0]   mu;
  logic             out_valid;
  logic [TAGW-1:0]  out_tag;
  logic [DATAW-1:0] out1;
  logic [DATAW-1:0] out2;
  logic             busy;

  modport master (
    output en, flush, in_valid, op, half, in_tag, a, b, w, p, mu,
    input  out_valid, out_tag, out1, out2, busy
  );

  modport slave (
    input  en, flush, in_valid, op, half, in_tag, a, b, w, p, mu,
    output out_valid, out_tag, out1, out2, busy
  );
endinterface

// File: rtl/barrett_mm.sv
// Pipelined Barrett modular multiplier, MUL_LAT register stages, result in [0,p).
module barrett_mm #(
  parameter int unsigned DATAW   = 14,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DATAW-1:0] x,
  input  logic [DATAW-1:0] y,
  input  logic [DATAW-1:0] p,
  input  logic [DATAW:0]   mu,
  output logic [DATAW-1:0] r
);
  localparam int unsigned PW   = 2 * DATAW;
  localparam int unsigned QW   = 2 * DATAW + 2;
  localparam int unsigned RW   = DATAW + 2;
  localparam int unsigned NDLY = MUL_LAT - 2;

  logic [PW-1:0]    t1_q;
  logic [RW-1:0]    t2_q;
  logic [DATAW:0]   q2_q;
  logic [DATAW:0]   q_d;
  logic [RW-1:0]    r0;
  logic [RW-1:0]    r1;
  logic [DATAW-1:0] r_red;
  logic [DATAW-1:0] dly_q [NDLY];

  // The quotient estimate undershoots by at most 2, so r0 < 3p fits RW bits.
  always_comb begin
    q_d   = (DATAW+1)'((QW'(t1_q[PW-1:DATAW-1]) * QW'(mu)) >> (DATAW + 1));
    r0    = t2_q - RW'(RW'(q2_q) * RW'(p));
    r1    = (r0 >= RW'(p)) ? r0 - RW'(p) : r0;
    r_red = DATAW'((r1 >= RW'(p)) ? r1 - RW'(p) : r1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_q <= '0;
      t2_q <= '0;
      q2_q <= '0;
      for (int j = 0; j < NDLY; j++) dly_q[j] <= '0;
    end else if (en) begin
      t1_q     <= PW'(x) * PW'(y);
      t2_q     <= t1_q[RW-1:0];
      q2_q     <= q_d;
      dly_q[0] <= r_red;
      for (int j = 1; j < NDLY; j++) dly_q[j] <= dly_q[j-1];
    end
  end

  assign r = dly_q[NDLY-1];

endmodule

// File: rtl/bfu_v1.sv
// Stallable CT/GS/MUL/BYPASS butterfly with a Barrett multiplier core and fixed MUL_LAT+2 latency.
module bfu_v1
  import ntt_bfu_pkg::*;
#(
  parameter int unsigned DATAW   = 14,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned TAGW    = 8
) (
  input logic     clk,
  input logic     rst,
  bfu_v1_if.slave bus
);

  function automatic logic [DATAW-1:0] mod_add(input logic [DATAW-1:0] x, y, m);
    logic [DATAW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, m}) ? DATAW'(s - {1'b0, m}) : DATAW'(s);
  endfunction

  function automatic logic [DATAW-1:0] mod_sub(input logic [DATAW-1:0] x, y, m);
    return (x >= y) ? x - y : DATAW'({1'b0, x} + {1'b0, m} - {1'b0, y});
  endfunction

  function automatic logic [DATAW-1:0] mod_half(input logic [DATAW-1:0] x, m);
    return x[0] ? DATAW'(({1'b0, x} + {1'b0, m}) >> 1) : (x >> 1);
  endfunction

  op_e              op_in;
  logic [DATAW-1:0] s0_x_d, s0_y_d, s0_add_d;
  logic [DATAW-1:0] s0_x_q, s0_y_q;
  bfu_sb_t          sb_q   [MUL_LAT+1];
  logic [TAGW-1:0]  tag_q  [MUL_LAT+1];
  logic [DATAW-1:0] add_q  [MUL_LAT+1];
  logic [DATAW-1:0] side_q [MUL_LAT+1];
  logic [DATAW-1:0] mm_r;
  logic [DATAW-1:0] f_r1_d, f_r2_d, f_r1_q, f_r2_q;
  bfu_sb_t          f_sb_q;
  logic [TAGW-1:0]  f_tag_q;
  logic             out_valid_q;
  logic [TAGW-1:0]  out_tag_q;
  logic [DATAW-1:0] out1_q, out2_q;
  logic             do_half;
  logic             busy_d;

  assign op_in = op_e'(bus.op);

  always_comb begin
    s0_x_d   = bus.a;
    s0_y_d   = bus.b;
    s0_add_d = bus.a;
    unique case (op_in)
      OP_CT: begin
        s0_x_d = bus.b;
        s0_y_d = bus.w;
      end
      OP_GS: begin
        s0_x_d   = mod_sub(bus.a, bus.b, bus.p);
        s0_y_d   = bus.w;
        s0_add_d = mod_add(bus.a, bus.b, bus.p);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q[0]   <= '0;
      tag_q[0]  <= '0;
      add_q[0]  <= '0;
      side_q[0] <= '0;
      s0_x_q    <= '0;
      s0_y_q    <= '0;
    end else begin
      if (bus.en) begin
        sb_q[0]   <= '{valid: bus.in_valid, op: op_in, half: bus.half};
        tag_q[0]  <= bus.in_tag;
        add_q[0]  <= s0_add_d;
        side_q[0] <= bus.b;
        s0_x_q    <= s0_x_d;
        s0_y_q    <= s0_y_d;
      end
      if (bus.flush) sb_q[0].valid <= 1'b0;
    end
  end

  // Side-band and addend lines run in lock-step with the multiplier stages.
  for (genvar i = 1; i <= MUL_LAT; i++) begin : g_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sb_q[i]   <= '0;
        tag_q[i]  <= '0;
        add_q[i]  <= '0;
        side_q[i] <= '0;
      end else begin
        if (bus.en) begin
          sb_q[i]   <= sb_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          add_q[i]  <= add_q[i-1];
          side_q[i] <= side_q[i-1];
        end
        if (bus.flush) sb_q[i].valid <= 1'b0;
      end
    end
  end

  barrett_mm #(
    .DATAW   (DATAW),
    .MUL_LAT (MUL_LAT)
  ) u_mm (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .x   (s0_x_q),
    .y   (s0_y_q),
    .p   (bus.p),
    .mu  (bus.mu),
    .r   (mm_r)
  );

  always_comb begin
    f_r1_d = add_q[MUL_LAT];
    f_r2_d = side_q[MUL_LAT];
    unique case (sb_q[MUL_LAT].op)
      OP_CT: begin
        f_r1_d = mod_add(add_q[MUL_LAT], mm_r, bus.p);
        f_r2_d = mod_sub(add_q[MUL_LAT], mm_r, bus.p);
      end
      OP_GS:   f_r2_d = mm_r;
      OP_MUL: begin
        f_r1_d = mm_r;
        f_r2_d = '0;
      end
      default: ;
    endcase
  end

  assign do_half = (f_sb_q.op == OP_GS) && f_sb_q.half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_sb_q      <= '0;
      f_tag_q     <= '0;
      f_r1_q      <= '0;
      f_r2_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
    end else begin
      if (bus.en) begin
        f_sb_q      <= sb_q[MUL_LAT];
        f_tag_q     <= tag_q[MUL_LAT];
        f_r1_q      <= f_r1_d;
        f_r2_q      <= f_r2_d;
        out_valid_q <= f_sb_q.valid;
        out_tag_q   <= f_tag_q;
        out1_q      <= do_half ? mod_half(f_r1_q, bus.p) : f_r1_q;
        out2_q      <= do_half ? mod_half(f_r2_q, bus.p) : f_r2_q;
      end
      if (bus.flush) begin
        f_sb_q.valid <= 1'b0;
        out_valid_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_d = f_sb_q.valid | out_valid_q;
    for (int i = 0; i <= MUL_LAT; i++) busy_d = busy_d | sb_q[i].valid;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.busy      = busy_d;

endmodule

// File: tb/tb_bfu_v1.sv
// Self-checking bench for bfu_v1: directed vectors, random streams, stalls, flush and reset.
module tb_bfu_v1;
  import ntt_bfu_pkg::*;

  localparam int unsigned DATAW   = 14;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned TAGW    = 8;
  localparam int P   = 12289;
  localparam int MU  = 21843;
  localparam int LAT = int'(bfu_lat(MUL_LAT));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfu_v1_if #(.DATAW(DATAW), .TAGW(TAGW)) bus ();

  bfu_v1 #(
    .DATAW   (DATAW),
    .MUL_LAT (MUL_LAT),
    .TAGW    (TAGW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due;
    int tag;
    int o1;
    int o2;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_v;
  int   nedge;
  int   total;
  int   bad;

  function automatic int halve(input int x);
    return (x % 2 != 0) ? (x + P) / 2 : x / 2;
  endfunction

  // Reference arithmetic straight from the mode definitions.
  task automatic model(input int op, input bit hf, input int a, b, w, output int o1, o2);
    int m;
    case (op)
      0: begin
        m  = (b * w) % P;
        o1 = (a + m) % P;
        o2 = (a - m + P) % P;
      end
      1: begin
        o1 = (a + b) % P;
        o2 = (((a - b + P) % P) * w) % P;
        if (hf) begin
          o1 = halve(o1);
          o2 = halve(o2);
        end
      end
      2: begin
        o1 = (a * b) % P;
        o2 = 0;
      end
      default: begin
        o1 = a;
        o2 = b;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic chk_zero();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out1", bus.out1, 0);
    check("rst_out2", bus.out2, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_busy", bus.busy, 0);
  endtask

  task automatic drive(input bit en, fl, vld, input int op, input bit hf,
                       input int a, b, w, tag);
    bus.en       = en;
    bus.flush    = fl;
    bus.in_valid = vld;
    bus.op       = 2'(op);
    bus.half     = hf;
    bus.a        = 14'(a);
    bus.b        = 14'(b);
    bus.w        = 14'(w);
    bus.in_tag   = 8'(tag);
  endtask

  task automatic drive_rand(input bit en, vld);
    drive(en, 1'b0, vld, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(0, P - 1), $urandom_range(0, P - 1), $urandom_range(0, P - 1),
          $urandom_range(0, 255));
  endtask

  // Advance one clock, update the model from the inputs that were sampled, compare outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      cur_v = 1'b0;
      chk_zero();
    end else begin
      if (bus.flush) begin
        q.delete();
        cur_v = 1'b0;
      end else if (bus.en) begin
        nedge++;
        if (bus.in_valid) begin
          e.due = nedge + LAT;
          e.tag = int'(bus.in_tag);
          model(int'(bus.op), bus.half, int'(bus.a), int'(bus.b), int'(bus.w), e.o1, e.o2);
          q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == nedge) begin
          cur   = q.pop_front();
          cur_v = 1'b1;
        end else begin
          cur_v = 1'b0;
        end
      end
      check("out_valid", bus.out_valid, cur_v);
      check("busy", bus.busy, (q.size() > 0) || cur_v);
      if (cur_v) begin
        check("out_tag", bus.out_tag, cur.tag);
        check("out1", bus.out1, cur.o1);
        check("out2", bus.out2, cur.o2);
      end
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    total = 0;
    bad   = 0;
    nedge = 0;
    cur_v = 1'b0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
    bus.p  = 14'(P);
    bus.mu = 15'(MU);
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b0;

    // Directed vectors, back to back
    drive(1'b1, 1'b0, 1'b1, 0, 1'b0, 5, 3, 7, 8'h11);         tick();
    drive(1'b1, 1'b0, 1'b1, 1, 1'b0, 5, 3, 7, 8'h22);         tick();
    drive(1'b1, 1'b0, 1'b1, 1, 1'b1, 5, 3, 7, 8'h33);         tick();
    drive(1'b1, 1'b0, 1'b1, 1, 1'b1, 4, 3, 1, 8'h44);         tick();
    drive(1'b1, 1'b0, 1'b1, 2, 1'b0, 12288, 12288, 5, 8'h55); tick();
    drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 100, 200, 9, 8'h66);     tick();
    drive(1'b1, 1'b0, 1'b1, 2, 1'b1, 0, 12288, 0, 8'h77);     tick();
    bubbles(LAT + 2);

    // 20 random ops, one per cycle
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    bubbles(LAT + 2);

    // 10-op stream with en toggled randomly
    n = 0;
    guard = 0;
    while (n < 10 && guard < 500) begin
      bit e;
      e = ($urandom_range(0, 2) != 0);
      drive_rand(e, 1'b1);
      tick();
      if (e) n++;
      guard++;
    end
    check("stall_issue", n, 10);
    guard = 0;
    while ((q.size() > 0 || cur_v) && guard < 200) begin
      drive_rand(1'($urandom_range(0, 1)), 1'b0);
      tick();
      guard++;
    end
    check("stall_drain", q.size(), 0);
    bubbles(2);

    // Flush with three ops in flight; the same-cycle input is dropped
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    drive_rand(1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bubbles(LAT + 2);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1 chk_zero();
    tick();
    #1 rst = 1'b0;
    bubbles(LAT + 2);

    // Recovery: stream still works after reset
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    bubbles(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
